mod_serial_tx_8: RTL
====================

# mod_serial_tx_8

Parallel-in, serial-out framed transmitter: a parameterized bit-rate divider, a bit counter and a load/shift register, behaving as a 74x161 + 74x165 chain with framing control. Accepts one 8-bit word per valid/ready handshake and emits it on a single idle-high line as start bit, 8 data bits, optional even parity and stop bit. It is the driving end of the library's serial link and is the intended stimulus source for serial-input parts and their receivers.

## Interface
- DIV, default 4: clock cycles per serial bit; legal range 1..65535; counter width = $clog2(DIV), minimum 1 bit.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- D  input  [0:7]  parallel data word; D[0] is transmitted first.
- VALID  input  1  word on D is offered for transmission.
- READY  output  1  transmitter can accept a word this cycle.
- SER_OUT  output  1  serial line; idle = 1.
- BUSY  output  1  frame in progress (state != IDLE).

## Operation
- Reset values: SER_OUT=1, READY=1, BUSY=0, state=IDLE, shift register=0, both counters=0.
- RST asserted mid-frame aborts the frame: SER_OUT returns to 1 asynchronously. The partial frame is not resumed and the held word is discarded.
- Handshake: a word is accepted on a rising edge where VALID=1 and READY=1. D is captured into the shift register on that edge.
- VALID while READY=0 is ignored. D is not sampled.
- D and VALID may change freely after acceptance.
- The state machine has five states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: SER_OUT=1. On accept, go to START with div counter=0.
  - START: SER_OUT=0 for DIV cycles, then go to DATA with bit counter=0.
  - DATA: SER_OUT=shift[0] for DIV cycles, then shift toward index 0 and increment the bit counter. After bit 7, go to PARITY if PARITY is compiled in, otherwise go to STOP.
  - PARITY: SER_OUT=XOR of the 8 accepted bits (even parity) for DIV cycles, then go to STOP.
  - STOP: SER_OUT=1 for DIV cycles, then go to IDLE.
- The div counter counts 0..DIV-1 and wraps to 0 at every bit boundary. With DIV=1, every bit lasts exactly one cycle.
- Parity is computed from the captured word, never from live D.
- READY=0 and BUSY=1 in every state except IDLE.

## Timing
- All outputs are registered. No combinational path exists from D or VALID to any output.
- Acceptance on edge k: at edge k+1, SER_OUT=0, READY=0 and BUSY=1.
- Bit n of the frame (start=0, data 1..8, then parity, then stop) is driven from edge k+1+n*DIV through edge k+(n+1)*DIV.
- Frame length F is 10 bits, or 11 with parity. The frame occupies F*DIV cycles.
- At edge k+F*DIV+1, the block returns to IDLE: READY=1 and BUSY=0.
- Back-to-back frames: the earliest next acceptance is edge k+F*DIV+1. This gives exactly one idle cycle of SER_OUT=1 between the stop bit and the next start bit.
- With VALID held high continuously, the frame period is F*DIV+1 cycles.

## Configuration
- MOD_SERIAL_TX_8_PARITY_EN defined: the PARITY state is present and frames are 11 bits (even parity bit between bit 7 and stop).
- MOD_SERIAL_TX_8_PARITY_EN undefined: the PARITY state and parity logic are removed, DATA goes directly to STOP, and frames are 10 bits.

## Test plan
- Reset: hold RST=1 for 3 cycles with VALID=1 -> SER_OUT=1, READY=1, BUSY=0 throughout, and no word is accepted.
- Single frame, DIV=4, no parity: D=8'b1010_0101 accepted at edge k -> SER_OUT sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. READY=1 again at edge k+41.
- Parity, DIV=4: D=8'b1110_0000 -> parity bit=1 and frame=0,1,1,1,0,0,0,0,0,1,1 (44 cycles). D=8'b1100_0000 -> parity bit=0.
- Back-to-back, DIV=1, VALID held high, D=8'hFF then 8'h00 -> exactly one idle high cycle between the first stop bit and the second start bit, and frame period=11 cycles without parity.
- Ignored offers: change D and pulse VALID while BUSY=1 -> the transmitted frame is unchanged and no extra frame follows.
- Reset mid-frame: assert RST during data bit 3 -> SER_OUT=1 immediately, READY=1 after release, and the next accepted word transmits from its start bit.

Source files
------------

// File: rtl/mod_serial_tx_8.sv
// ============================================================================
// Module   : mod_serial_tx_8
// Purpose  : Framed parallel-in/serial-out transmitter (start, 8 data, opt. even
//            parity, stop) with a DIV-cycle bit-rate divider. Optional feature
//            macro: MOD_SERIAL_TX_8_PARITY_EN (adds the even parity bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_serial_tx_8 #(
    parameter int DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [0:7] D,
    input  logic       VALID,
    output logic       READY,
    output logic       SER_OUT,
    output logic       BUSY
);

    localparam int                 c_cnt_w    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef MOD_SERIAL_TX_8_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_div;
    logic [2:0]         r_bit;
    logic [0:7]         r_shift;
    logic               r_ser;
    logic               r_ready;
    logic               r_busy;
`ifdef MOD_SERIAL_TX_8_PARITY_EN
    logic               r_par;
`endif

    // Each output register is loaded with the value of the bit that starts
    // on the same edge, so the line never lags the state by a cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ser   <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
`ifdef MOD_SERIAL_TX_8_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (r_state == ST_IDLE) begin
            if (VALID && r_ready) begin
                r_shift <= D;
`ifdef MOD_SERIAL_TX_8_PARITY_EN
                r_par   <= ^D;
`endif
                r_state <= ST_START;
                r_div   <= '0;
                r_ser   <= 1'b0;
                r_ready <= 1'b0;
                r_busy  <= 1'b1;
            end
        end else if (r_div != c_div_last) begin
            r_div <= r_div + 1'b1;
        end else begin
            r_div <= '0;
            case (r_state)
                ST_START: begin
                    r_state <= ST_DATA;
                    r_bit   <= '0;
                    r_ser   <= r_shift[0];
                end
                ST_DATA: begin
                    r_shift <= {r_shift[1:7], 1'b0};
                    r_bit   <= r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef MOD_SERIAL_TX_8_PARITY_EN
                        r_state <= ST_PARITY;
                        r_ser   <= r_par;
`else
                        r_state <= ST_STOP;
                        r_ser   <= 1'b1;
`endif
                    end else begin
                        r_ser <= r_shift[1];
                    end
                end
`ifdef MOD_SERIAL_TX_8_PARITY_EN
                ST_PARITY: begin
                    r_state <= ST_STOP;
                    r_ser   <= 1'b1;
                end
`endif
                default: begin
                    // End of stop bit, or recovery from an illegal encoding.
                    r_state <= ST_IDLE;
                    r_ser   <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign READY   = r_ready;
    assign SER_OUT = r_ser;
    assign BUSY    = r_busy;

endmodule

`default_nettype wire
